snake_mover: RTL
================

# snake_mover

Snake body/motion engine: consumes the 2-bit heading from the navigation state machine and advances the snake one grid cell per move tick. Holds the segment list, handles screen wrap, growth on target capture and self-collision. Sits between the navigation state machine (upstream) and the VGA colour/score logic (downstream), answering per-pixel "is snake" queries.

## Interface
- H_CELLS, 160: grid width in cells
- V_CELLS, 120: grid height in cells
- X_W, 8 / Y_W, 7: coordinate widths
- MAX_LEN, 32: segment storage depth
- INIT_LEN, 4: length after reset (2..MAX_LEN)
- TICK_DIV, 10_000_000: CLK cycles per move (10 Hz at 100 MHz)
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- ENABLE  in  1  game running; low freezes tick counter and motion
- DIR  in  2  requested heading: 00 right, 01 down, 10 left, 11 up
- TARGET_X / TARGET_Y  in  X_W / Y_W  current target cell
- PIX_X / PIX_Y  in  X_W / Y_W  cell being drawn
- HEAD_X / HEAD_Y  out  X_W / Y_W  head cell
- LENGTH  out  6  current length
- MOVE_TICK  out  1  one-cycle pulse, move commit cycle
- TARGET_REACHED  out  1  one-cycle pulse, target eaten
- COLLISION  out  1  level, high in DEAD
- SNAKE_HIT  out  1  registered: PIX cell is a live segment

## Operation
- States: IDLE -> RUN when ENABLE=1; RUN -> DEAD on self-collision; DEAD held until RESET. RUN with ENABLE=0 pauses (counter and segments frozen).
- Reset: head (H_CELLS/2, V_CELLS/2); segment i at (H_CELLS/2 - i, V_CELLS/2); LENGTH=INIT_LEN; heading right; counter 0; all pulses, COLLISION, SNAKE_HIT = 0; state IDLE.
- Heading: DIR sampled only in the tick cycle; reversal (DIR XOR heading == 2'b10) ignored, heading kept.
- Next head: right x==H_CELLS-1 ? 0 : x+1; left x==0 ? H_CELLS-1 : x-1; same for y (down = +1). No wall death.
- Growth: next head == TARGET -> LENGTH+1 (saturate at MAX_LEN), TARGET_REACHED pulse; old tail stays live.
- Collision: next head compared with segments 1..LENGTH-2 (1..LENGTH-1 when growing this tick); vacating tail is legal. On hit: no move, no growth, state DEAD, COLLISION=1.
- Move: seg[i] <= seg[i-1] for all i, seg[0] <= next head; segments >= LENGTH ignored everywhere.
- SNAKE_HIT: OR over i<LENGTH of (seg[i]==PIX), registered.

## Timing
- Counter 0..TICK_DIV-1 in RUN & ENABLE; MOVE_TICK high when counter == TICK_DIV-1; move, growth, collision commit on that edge.
- First move TICK_DIV cycles after entering RUN.
- HEAD_X/Y, LENGTH, COLLISION visible the cycle after MOVE_TICK; TARGET_REACHED asserted that same following cycle, one cycle wide.
- SNAKE_HIT latency 1 cycle from PIX_X/PIX_Y.
- Target growth and collision same tick: collision wins (no growth, no TARGET_REACHED).
- RESET mid-run: all state to reset values immediately, no clock edge needed.

## Structure
- Package snake_pkg: DIR_RIGHT/DOWN/LEFT/UP encodings, IDLE/RUN/DEAD state encoding, default grid constants; shared with the navigation state machine.
- Sub-module snake_tick_gen: parameterised TICK_DIV counter with enable, async reset, MOVE_TICK output.

## Test plan
Params H_CELLS=8, V_CELLS=6, MAX_LEN=8, INIT_LEN=3, TICK_DIV=4; reset head (4,3), body (3,3),(2,3).
- ENABLE=1, DIR=00 -> MOVE_TICK every 4 cycles; heads (5,3),(6,3),(7,3),(0,3) (wrap).
- Heading right, DIR=10 at tick -> head (5,3), heading unchanged; DIR=01 next tick -> (5,4).
- TARGET=(5,3), DIR=00 -> head (5,3), TARGET_REACHED one cycle, LENGTH 3->4, tail (2,3) still SNAKE_HIT=1.
- Grow to LENGTH=5, then DIR 01,10,11 on consecutive ticks -> COLLISION=1 on third turn, head unchanged, no further MOVE_TICK, holds until RESET.
- ENABLE=0 for 10 cycles mid-count -> no MOVE_TICK, head frozen; resumes remaining count on ENABLE=1.
- RESET pulsed between clock edges after 3 moves -> head (4,3), LENGTH=3 before next edge; PIX (2,3) -> SNAKE_HIT=1 one cycle later, PIX (7,0) -> 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: headings, motion-engine states and default grid geometry.
// Also used by the navigation state machine, so keep encodings stable.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } state_t;

  localparam int H_CELLS_DEF  = 160;
  localparam int V_CELLS_DEF  = 120;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int MAX_LEN_DEF  = 32;
  localparam int INIT_LEN_DEF = 4;
  localparam int TICK_DIV_DEF = 10_000_000;

  // Opposite headings differ only in the upper bit.
  function automatic logic is_reversal(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-rate divider: counts 0..TICK_DIV-1 while enabled and flags the last count.
// tick is combinational so the move commits on the same edge that wraps the counter.
module snake_tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/snake_mover.sv
// Snake motion engine: advances the segment list one cell per move tick with wrap,
// growth on target capture, self-collision detection and a registered per-pixel hit query.
module snake_mover
  import snake_pkg::*;
#(
  parameter int H_CELLS  = H_CELLS_DEF,
  parameter int V_CELLS  = V_CELLS_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int MAX_LEN  = MAX_LEN_DEF,
  parameter int INIT_LEN = INIT_LEN_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           ENABLE,
  input  logic [1:0]     DIR,
  input  logic [X_W-1:0] TARGET_X,
  input  logic [Y_W-1:0] TARGET_Y,
  input  logic [X_W-1:0] PIX_X,
  input  logic [Y_W-1:0] PIX_Y,
  output logic [X_W-1:0] HEAD_X,
  output logic [Y_W-1:0] HEAD_Y,
  output logic [5:0]     LENGTH,
  output logic           MOVE_TICK,
  output logic           TARGET_REACHED,
  output logic           COLLISION,
  output logic           SNAKE_HIT
);

  logic [X_W-1:0] seg_x [MAX_LEN];
  logic [Y_W-1:0] seg_y [MAX_LEN];
  logic [5:0]     len;
  state_t         state, state_nx;
  dir_t           heading, dir_eff;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic [5:0]     live_lim;
  logic           tick, grow, hit, reached, pix_hit, snake_hit_q;

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (CLK),
    .rst    (RESET),
    .enable ((state == RUN) && ENABLE),
    .tick   (tick)
  );

  always_comb begin
    dir_eff = is_reversal(DIR, heading) ? heading : dir_t'(DIR);
    nx = seg_x[0];
    ny = seg_y[0];
    case (dir_eff)
      DIR_RIGHT: nx = (seg_x[0] == X_W'(H_CELLS - 1)) ? '0 : seg_x[0] + X_W'(1);
      DIR_LEFT:  nx = (seg_x[0] == '0) ? X_W'(H_CELLS - 1) : seg_x[0] - X_W'(1);
      DIR_DOWN:  ny = (seg_y[0] == Y_W'(V_CELLS - 1)) ? '0 : seg_y[0] + Y_W'(1);
      default:   ny = (seg_y[0] == '0) ? Y_W'(V_CELLS - 1) : seg_y[0] - Y_W'(1);
    endcase
  end

  // The tail only vacates its cell when the snake is not growing this tick.
  always_comb begin
    grow     = (nx == TARGET_X) && (ny == TARGET_Y);
    live_lim = grow ? len : len - 6'd1;
    hit      = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((6'(i) < live_lim) && (seg_x[i] == nx) && (seg_y[i] == ny)) hit = 1'b1;
    end
  end

  always_comb begin
    pix_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < len) && (seg_x[i] == PIX_X) && (seg_y[i] == PIX_Y)) pix_hit = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ENABLE) state_nx = RUN;
      RUN:     if (tick && hit) state_nx = DEAD;
      DEAD:    state_nx = DEAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= X_W'(H_CELLS / 2 - i);
        seg_y[i] <= Y_W'(V_CELLS / 2);
      end
      len         <= 6'(INIT_LEN);
      heading     <= DIR_RIGHT;
      reached     <= 1'b0;
      snake_hit_q <= 1'b0;
    end else begin
      reached     <= 1'b0;
      snake_hit_q <= pix_hit;
      if (tick && !hit) begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= nx;
        seg_y[0] <= ny;
        heading  <= dir_eff;
        if (grow) begin
          reached <= 1'b1;
          if (len < 6'(MAX_LEN)) len <= len + 6'd1;
        end
      end
    end
  end

  assign HEAD_X         = seg_x[0];
  assign HEAD_Y         = seg_y[0];
  assign LENGTH         = len;
  assign MOVE_TICK      = tick;
  assign TARGET_REACHED = reached;
  assign COLLISION      = (state == DEAD);
  assign SNAKE_HIT      = snake_hit_q;

endmodule
